// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-outstanding cache port.
// Each port holds one request slot; the slot stays occupied until its response returns.
module mem_arbiter #(
   parameter int LS_PRIORITY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,
   input  logic        ls_req,
   input  logic        ls_mode,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [3:0]  ls_wstrb,
   output logic        ls_resp_valid,
   output logic [31:0] ls_resp_data,
   output logic        request_enable,
   output logic        req_mode,
   output logic [31:0] req_addr,
   output logic [31:0] req_wdata,
   output logic [3:0]  req_wstrb,
   input  logic        response_enable,
   input  logic [31:0] resp_data,
   output logic        err,
   output logic        o_dbg_busy,
   output logic        o_dbg_owner
);

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;
   localparam logic W_PRIO = (LS_PRIORITY != 0);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_owner;

   logic        r_if_pend;
   logic [31:0] r_if_addr;
   logic        r_ls_pend;
   logic        r_ls_mode;
   logic [31:0] r_ls_addr;
   logic [31:0] r_ls_wdata;
   logic [3:0]  r_ls_wstrb;

   logic        r_req_en;
   logic        r_req_mode;
   logic [31:0] r_req_addr;
   logic [31:0] r_req_wdata;
   logic [3:0]  r_req_wstrb;
   logic        r_if_rv;
   logic [31:0] r_if_rd;
   logic        r_ls_rv;
   logic [31:0] r_ls_rd;
   logic        r_err;

   logic        w_if_acc;
   logic        w_ls_acc;
   logic        w_if_drop;
   logic        w_ls_drop;
   logic        w_if_avail;
   logic        w_ls_avail;
   logic        w_done;
   logic        w_decide;
   logic        w_gnt_if;
   logic        w_gnt_ls;
   logic        w_stray;
   logic [31:0] w_if_addr_eff;
   logic        w_ls_mode_eff;
   logic [31:0] w_ls_addr_eff;
   logic [31:0] w_ls_wdata_eff;
   logic [3:0]  w_ls_wstrb_eff;

   // Next-state and grant decision. The owner's slot is still occupied while in
   // flight, so only the other port can compete at the response cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_if_acc       = if_req & ~r_if_pend;
      w_ls_acc       = ls_req & ~r_ls_pend;
      w_if_drop      = if_req & r_if_pend;
      w_ls_drop      = ls_req & r_ls_pend;
      w_if_avail     = (r_if_pend & ~((r_state == ST_BUSY) & (r_owner == OWN_IF))) | w_if_acc;
      w_ls_avail     = (r_ls_pend & ~((r_state == ST_BUSY) & (r_owner == OWN_LS))) | w_ls_acc;
      w_done         = (r_state == ST_BUSY) & response_enable;
      w_stray        = (r_state == ST_IDLE) & response_enable;
      w_decide       = (r_state == ST_IDLE) | w_done;
      w_gnt_ls       = w_decide & w_ls_avail & (W_PRIO | ~w_if_avail);
      w_gnt_if       = w_decide & w_if_avail & ~w_gnt_ls;
      w_if_addr_eff  = r_if_pend ? r_if_addr  : if_addr;
      w_ls_mode_eff  = r_ls_pend ? r_ls_mode  : ls_mode;
      w_ls_addr_eff  = r_ls_pend ? r_ls_addr  : ls_addr;
      w_ls_wdata_eff = r_ls_pend ? r_ls_wdata : ls_wdata;
      w_ls_wstrb_eff = r_ls_pend ? r_ls_wstrb : ls_wstrb;
      if (w_gnt_if | w_gnt_ls) begin
         w_state_nxt = ST_BUSY;
      end else if (w_done) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_IF;
         r_if_pend   <= 1'b0;
         r_if_addr   <= 32'h0;
         r_ls_pend   <= 1'b0;
         r_ls_mode   <= 1'b0;
         r_ls_addr   <= 32'h0;
         r_ls_wdata  <= 32'h0;
         r_ls_wstrb  <= 4'h0;
         r_req_en    <= 1'b0;
         r_req_mode  <= 1'b0;
         r_req_addr  <= 32'h0;
         r_req_wdata <= 32'h0;
         r_req_wstrb <= 4'h0;
         r_if_rv     <= 1'b0;
         r_if_rd     <= 32'h0;
         r_ls_rv     <= 1'b0;
         r_ls_rd     <= 32'h0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_gnt_if | w_gnt_ls) begin
            r_owner <= w_gnt_ls;
         end

         if (w_if_acc) begin
            r_if_pend <= 1'b1;
            r_if_addr <= if_addr;
         end else if (w_done && (r_owner == OWN_IF)) begin
            r_if_pend <= 1'b0;
         end

         if (w_ls_acc) begin
            r_ls_pend  <= 1'b1;
            r_ls_mode  <= ls_mode;
            r_ls_addr  <= ls_addr;
            r_ls_wdata <= ls_wdata;
            r_ls_wstrb <= ls_wstrb;
         end else if (w_done && (r_owner == OWN_LS)) begin
            r_ls_pend <= 1'b0;
         end

         r_req_en <= w_gnt_if | w_gnt_ls;
         if (w_gnt_ls) begin
            r_req_mode  <= w_ls_mode_eff;
            r_req_addr  <= w_ls_addr_eff;
            r_req_wdata <= w_ls_wdata_eff;
            r_req_wstrb <= w_ls_wstrb_eff;
         end else if (w_gnt_if) begin
            r_req_mode  <= 1'b0;
            r_req_addr  <= w_if_addr_eff;
            r_req_wdata <= 32'h0;
            r_req_wstrb <= 4'h0;
         end

         r_if_rv <= w_done & (r_owner == OWN_IF);
         r_ls_rv <= w_done & (r_owner == OWN_LS);
         if (w_done && (r_owner == OWN_IF)) begin
            r_if_rd <= resp_data;
         end
         if (w_done && (r_owner == OWN_LS)) begin
            r_ls_rd <= resp_data;
         end

         if (w_if_drop | w_ls_drop | w_stray) begin
            r_err <= 1'b1;
         end
      end
   end

   assign request_enable = r_req_en;
   assign req_mode       = r_req_mode;
   assign req_addr       = r_req_addr;
   assign req_wdata      = r_req_wdata;
   assign req_wstrb      = r_req_wstrb;
   assign if_resp_valid  = r_if_rv;
   assign if_resp_data   = r_if_rd;
   assign ls_resp_valid  = r_ls_rv;
   assign ls_resp_data   = r_ls_rd;
   assign err            = r_err;
   assign o_dbg_busy     = (r_state == ST_BUSY);
   assign o_dbg_owner    = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LS priority / IF priority) share one stimulus
// stream and are each compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        ls_req;
   logic        ls_mode;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_wstrb;
   logic        response_enable;
   logic [31:0] resp_data;

   logic        o_req_en   [2];
   logic        o_req_mode [2];
   logic [31:0] o_req_addr [2];
   logic [31:0] o_req_wdata[2];
   logic [3:0]  o_req_wstrb[2];
   logic        o_if_rv    [2];
   logic [31:0] o_if_rd    [2];
   logic        o_ls_rv    [2];
   logic [31:0] o_ls_rd    [2];
   logic        o_err      [2];
   logic        o_busy     [2];
   logic        o_owner    [2];

   int n_cmp = 0;
   int n_bad = 0;

   // Valid/ready note: every request and response here is a single-cycle pulse;
   // there is no back-pressure, a pulse is either accepted into a slot or dropped.

   mem_arbiter #(.LS_PRIORITY(1)) u_dut_ls (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_resp_valid(o_if_rv[0]), .if_resp_data(o_if_rd[0]),
      .ls_req(ls_req), .ls_mode(ls_mode), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
      .ls_resp_valid(o_ls_rv[0]), .ls_resp_data(o_ls_rd[0]),
      .request_enable(o_req_en[0]), .req_mode(o_req_mode[0]), .req_addr(o_req_addr[0]),
      .req_wdata(o_req_wdata[0]), .req_wstrb(o_req_wstrb[0]),
      .response_enable(response_enable), .resp_data(resp_data),
      .err(o_err[0]), .o_dbg_busy(o_busy[0]), .o_dbg_owner(o_owner[0])
   );

   mem_arbiter #(.LS_PRIORITY(0)) u_dut_if (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_resp_valid(o_if_rv[1]), .if_resp_data(o_if_rd[1]),
      .ls_req(ls_req), .ls_mode(ls_mode), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
      .ls_resp_valid(o_ls_rv[1]), .ls_resp_data(o_ls_rd[1]),
      .request_enable(o_req_en[1]), .req_mode(o_req_mode[1]), .req_addr(o_req_addr[1]),
      .req_wdata(o_req_wdata[1]), .req_wstrb(o_req_wstrb[1]),
      .response_enable(response_enable), .resp_data(resp_data),
      .err(o_err[1]), .o_dbg_busy(o_busy[1]), .o_dbg_owner(o_owner[1])
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model state: index [k] = instance, [p] = port (0 fetch, 1 load/store)
   bit          m_busy [2];
   int          m_owner[2];
   bit          m_pend [2][2];
   logic        m_mode [2][2];
   logic [31:0] m_addr [2][2];
   logic [31:0] m_wdata[2][2];
   logic [3:0]  m_wstrb[2][2];

   logic        e_req_en[2];
   logic        e_mode  [2];
   logic [31:0] e_addr  [2];
   logic [31:0] e_wdata [2];
   logic [3:0]  e_wstrb [2];
   logic        e_rv    [2][2];
   logic [31:0] e_rd    [2][2];
   logic        e_err   [2];

   logic [31:0] exp_q[$];

   bit          auto_cache = 1'b0;
   bit          c_busy     = 1'b0;
   int          c_cnt      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle of the arbiter at transaction level for instance k.
   task automatic model_step(input int k);
      bit req[2];
      int w;
      bit ls_wins;
      ls_wins = (k == 0);
      req[0] = if_req;
      req[1] = ls_req;
      e_req_en[k] = 1'b0;
      e_rv[k][0]  = 1'b0;
      e_rv[k][1]  = 1'b0;
      if (rst) begin
         m_busy[k] = 1'b0;
         m_owner[k] = 0;
         e_mode[k] = 1'b0; e_addr[k] = 32'h0; e_wdata[k] = 32'h0; e_wstrb[k] = 4'h0;
         e_err[k] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            m_pend[k][p] = 1'b0;
            e_rd[k][p] = 32'h0;
         end
         if (k == 0) exp_q.delete();
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (req[p]) begin
               if (m_pend[k][p]) begin
                  e_err[k] = 1'b1;
               end else begin
                  m_pend[k][p]  = 1'b1;
                  m_mode[k][p]  = (p == 1) ? ls_mode  : 1'b0;
                  m_addr[k][p]  = (p == 1) ? ls_addr  : if_addr;
                  m_wdata[k][p] = (p == 1) ? ls_wdata : 32'h0;
                  m_wstrb[k][p] = (p == 1) ? ls_wstrb : 4'h0;
               end
            end
         end
         if (response_enable) begin
            if (!m_busy[k]) begin
               e_err[k] = 1'b1;
            end else begin
               e_rv[k][m_owner[k]] = 1'b1;
               e_rd[k][m_owner[k]] = resp_data;
               m_pend[k][m_owner[k]] = 1'b0;
               m_busy[k] = 1'b0;
            end
         end
         if (!m_busy[k]) begin
            w = -1;
            if (m_pend[k][0] && m_pend[k][1]) w = ls_wins ? 1 : 0;
            else if (m_pend[k][1]) w = 1;
            else if (m_pend[k][0]) w = 0;
            if (w >= 0) begin
               m_busy[k]   = 1'b1;
               m_owner[k]  = w;
               e_req_en[k] = 1'b1;
               e_mode[k]   = m_mode[k][w];
               e_addr[k]   = m_addr[k][w];
               e_wdata[k]  = m_wdata[k][w];
               e_wstrb[k]  = m_wstrb[k][w];
               if (k == 0) exp_q.push_back(m_addr[k][w]);
            end
         end
      end
   endtask

   task automatic compare_all(input int k);
      string s;
      s = (k == 0) ? "lsprio" : "ifprio";
      chk({s, ".request_enable"}, {31'h0, o_req_en[k]}, {31'h0, e_req_en[k]});
      chk({s, ".req_mode"},       {31'h0, o_req_mode[k]}, {31'h0, e_mode[k]});
      chk({s, ".req_addr"},       o_req_addr[k], e_addr[k]);
      if (e_mode[k]) chk({s, ".req_wdata"}, o_req_wdata[k], e_wdata[k]);
      chk({s, ".req_wstrb"},      {28'h0, o_req_wstrb[k]}, {28'h0, e_wstrb[k]});
      chk({s, ".if_resp_valid"},  {31'h0, o_if_rv[k]}, {31'h0, e_rv[k][0]});
      chk({s, ".ls_resp_valid"},  {31'h0, o_ls_rv[k]}, {31'h0, e_rv[k][1]});
      chk({s, ".if_resp_data"},   o_if_rd[k], e_rd[k][0]);
      chk({s, ".ls_resp_data"},   o_ls_rd[k], e_rd[k][1]);
      chk({s, ".err"},            {31'h0, o_err[k]}, {31'h0, e_err[k]});
      chk({s, ".busy"},           {31'h0, o_busy[k]}, {31'h0, m_busy[k]});
      chk({s, ".resp_exclusive"}, {31'h0, o_if_rv[k] & o_ls_rv[k]}, 32'h0);
   endtask

   // driver: apply current inputs for one cycle, check, then clear pulses
   task automatic cyc();
      logic [31:0] a;
      bit was_rst;
      was_rst = rst;
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      compare_all(0);
      compare_all(1);
      if (o_req_en[0]) begin
         if (exp_q.size() == 0) begin
            chk("sb.unexpected_request", o_req_addr[0], 32'hFFFF_FFFF);
         end else begin
            a = exp_q.pop_front();
            chk("sb.request_addr", o_req_addr[0], a);
         end
      end
      rst = 1'b0;
      if_req = 1'b0;
      ls_req = 1'b0;
      response_enable = 1'b0;
      if (was_rst) c_busy = 1'b0;
      if (auto_cache) begin
         if (c_busy) begin
            c_cnt--;
            if (c_cnt == 0) begin
               response_enable = 1'b1;
               resp_data = $urandom;
               c_busy = 1'b0;
            end
         end
         if (o_req_en[0]) begin
            c_busy = 1'b1;
            c_cnt = $urandom_range(1, 4);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int  n_resp;
      int  budget;
      bit  last_ls;
      bit  cur_ls;
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_mode = 1'b0;
      ls_addr = 32'h0; ls_wdata = 32'h0; ls_wstrb = 4'h0; response_enable = 1'b0; resp_data = 32'h0;
      @(negedge clk);

      // reset state
      rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; cyc();
      chk("reset.request_enable", {31'h0, o_req_en[0]}, 32'h0);
      chk("reset.err", {31'h0, o_err[0]}, 32'h0);
      idle(1);
      chk("reset.pulse_discarded", {31'h0, o_req_en[0]}, 32'h0);

      // single fetch: request at cycle 0, response at cycle 5
      if_req = 1'b1; if_addr = 32'h100; cyc();
      chk("fetch.request_enable", {31'h0, o_req_en[0]}, 32'h1);
      chk("fetch.req_addr", o_req_addr[0], 32'h100);
      chk("fetch.req_mode", {31'h0, o_req_mode[0]}, 32'h0);
      idle(4);
      response_enable = 1'b1; resp_data = 32'hDEADBEEF; cyc();
      chk("fetch.if_resp_valid", {31'h0, o_if_rv[0]}, 32'h1);
      chk("fetch.if_resp_data", o_if_rd[0], 32'hDEADBEEF);
      idle(2);

      // simultaneous requests: priority differs between the two instances
      if_req = 1'b1; if_addr = 32'h300;
      ls_req = 1'b1; ls_mode = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h12345678; ls_wstrb = 4'hF;
      cyc();
      chk("prio1.first_addr", o_req_addr[0], 32'h200);
      chk("prio1.first_mode", {31'h0, o_req_mode[0]}, 32'h1);
      chk("prio1.first_wdata", o_req_wdata[0], 32'h12345678);
      chk("prio0.first_addr", o_req_addr[1], 32'h300);
      idle(2);
      response_enable = 1'b1; resp_data = 32'h0000A5A5; cyc();
      chk("prio1.ls_resp_valid", {31'h0, o_ls_rv[0]}, 32'h1);
      chk("prio1.b2b_request", {31'h0, o_req_en[0]}, 32'h1);
      chk("prio1.b2b_addr", o_req_addr[0], 32'h300);
      chk("prio1.b2b_wstrb", {28'h0, o_req_wstrb[0]}, 32'h0);
      chk("prio0.b2b_addr", o_req_addr[1], 32'h200);
      response_enable = 1'b1; resp_data = 32'h0BADF00D; cyc();
      chk("prio1.if_resp_data", o_if_rd[0], 32'h0BADF00D);
      idle(2);

      // duplicate fetch while outstanding
      if_req = 1'b1; if_addr = 32'h400; cyc();
      if_req = 1'b1; if_addr = 32'h500; cyc();
      chk("drop.err", {31'h0, o_err[0]}, 32'h1);
      idle(1);
      response_enable = 1'b1; resp_data = 32'h44444444; cyc();
      chk("drop.inflight_delivered", o_if_rd[0], 32'h44444444);
      idle(3);
      chk("drop.no_reissue", {31'h0, o_req_en[0]}, 32'h0);
      chk("drop.err_sticky", {31'h0, o_err[0]}, 32'h1);

      // reset mid-transaction, then a stray response
      rst = 1'b1; cyc();
      chk("rst.err_cleared", {31'h0, o_err[0]}, 32'h0);
      ls_req = 1'b1; ls_mode = 1'b0; ls_addr = 32'h700; cyc();
      rst = 1'b1; cyc();
      response_enable = 1'b1; resp_data = 32'h77777777; cyc();
      chk("stray.no_ls_valid", {31'h0, o_ls_rv[0]}, 32'h0);
      chk("stray.err", {31'h0, o_err[0]}, 32'h1);
      if_req = 1'b1; if_addr = 32'h600; cyc();
      chk("post_rst.request_addr", o_req_addr[0], 32'h600);
      response_enable = 1'b1; resp_data = 32'h66666666; cyc();
      chk("post_rst.if_resp_data", o_if_rd[0], 32'h66666666);

      // saturation with an automatic cache of random latency
      rst = 1'b1; cyc();
      auto_cache = 1'b1;
      if_req = 1'b1; if_addr = $urandom;
      ls_req = 1'b1; ls_mode = 1'($urandom_range(0, 1)); ls_addr = $urandom; ls_wdata = $urandom;
      ls_wstrb = 4'($urandom_range(0, 15));
      n_resp = 0; budget = 0; last_ls = 1'b0;
      while (n_resp < 20 && budget < 2000) begin
         cyc();
         budget++;
         if (o_if_rv[0] || o_ls_rv[0]) begin
            cur_ls = o_ls_rv[0];
            if (n_resp > 0) chk("sat.alternation", {31'h0, cur_ls}, {31'h0, ~last_ls});
            last_ls = cur_ls;
            n_resp++;
         end
         if (o_if_rv[0]) begin if_req = 1'b1; if_addr = $urandom; end
         if (o_ls_rv[0]) begin
            ls_req = 1'b1; ls_mode = 1'($urandom_range(0, 1)); ls_addr = $urandom;
            ls_wdata = $urandom; ls_wstrb = 4'($urandom_range(0, 15));
         end
      end
      chk("sat.responses", n_resp, 20);
      chk("sat.err", {31'h0, o_err[0]}, 32'h0);

      // random traffic, including drops and occasional reset
      for (int i = 0; i < 400; i++) begin
         if_req = ($urandom_range(0, 3) == 0); if_addr = $urandom;
         ls_req = ($urandom_range(0, 3) == 0); ls_mode = 1'($urandom_range(0, 1));
         ls_addr = $urandom; ls_wdata = $urandom; ls_wstrb = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 149) == 0);
         cyc();
      end
      auto_cache = 1'b0;
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
